// File: rtl/led8_seq_arbiter.sv
// led8_seq_arbiter: shares the 8-bit LED bank between MicroBlaze GPIO writes
// and a local pattern generator. The pattern owns the LEDs by default. Any
// software write takes ownership at once. Ownership returns to the pattern
// after IDLE_STEPS pattern steps with no software write.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   gpio_data  LED value from GPIO, qualified by gpio_wr
//   gpio_wr    single-cycle write strobe
//   pat_sel    pattern select: 00 chase, 01 bounce, 10 blink, 11 count
//   led_o      registered LED drive
//   owner_o    0 = pattern owns LEDs, 1 = CPU owns LEDs
//   step_o     one-cycle pulse on each pattern step
module led8_seq_arbiter #(
    parameter int unsigned STEP_CYCLES = 5_000_000,
    parameter int unsigned IDLE_STEPS  = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] gpio_data,
    input  logic       gpio_wr,
    input  logic [1:0] pat_sel,
    output logic [7:0] led_o,
    output logic       owner_o,
    output logic       step_o
);

    localparam int unsigned SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned IW = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_STEPS - 1);

    localparam logic [1:0] SEL_CHASE  = 2'b00;
    localparam logic [1:0] SEL_BOUNCE = 2'b01;
    localparam logic [1:0] SEL_BLINK  = 2'b10;
    localparam logic [1:0] SEL_COUNT  = 2'b11;

    typedef enum logic {
        ST_PAT = 1'b0,
        ST_CPU = 1'b1
    } state_t;

    state_t        state, state_d;
    logic [7:0]    cpu_data, cpu_data_d;
    logic [IW-1:0] idle_cnt, idle_d;

    logic [SW-1:0] step_cnt, step_cnt_d;
    logic          step_hit;

    logic [7:0]    pat, pat_d;
    logic          dir, dir_d;
    logic [1:0]    sel_q, sel_d;

    logic [7:0]    led_d;

    // Free-running step timer; step_hit marks the last cycle of each step.
    assign step_hit   = (step_cnt == STEP_LAST);
    assign step_cnt_d = step_hit ? '0 : step_cnt + SW'(1);

    // Pattern generator next value; pat_sel is only looked at on step cycles.
    always_comb begin
        pat_d = pat;
        dir_d = dir;
        sel_d = sel_q;
        if (step_hit) begin
            if (pat_sel != sel_q) begin
                sel_d = pat_sel;
                dir_d = 1'b0;
                pat_d = (pat_sel == SEL_CHASE || pat_sel == SEL_BOUNCE) ? 8'h01 : 8'h00;
            end else begin
                case (sel_q)
                    SEL_CHASE: pat_d = {pat[6:0], pat[7]};
                    SEL_BOUNCE: begin
                        // Turn around at either end so each end shows once per pass.
                        if (!dir) begin
                            if (pat == 8'h80) begin
                                dir_d = 1'b1;
                                pat_d = pat >> 1;
                            end else begin
                                pat_d = pat << 1;
                            end
                        end else begin
                            if (pat == 8'h01) begin
                                dir_d = 1'b0;
                                pat_d = pat << 1;
                            end else begin
                                pat_d = pat >> 1;
                            end
                        end
                    end
                    SEL_BLINK: pat_d = ~pat;
                    SEL_COUNT: pat_d = pat + 8'h01;
                    default:   pat_d = pat;
                endcase
            end
        end
    end

    // Arbiter state register, with the captured CPU data and idle counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_PAT;
            cpu_data <= 8'h00;
            idle_cnt <= '0;
        end else begin
            state    <= state_d;
            cpu_data <= cpu_data_d;
            idle_cnt <= idle_d;
        end
    end

    // Arbiter next state; a write always beats a coincident timeout.
    always_comb begin
        state_d    = state;
        cpu_data_d = cpu_data;
        idle_d     = idle_cnt;
        case (state)
            ST_PAT: begin
                if (gpio_wr) begin
                    state_d    = ST_CPU;
                    cpu_data_d = gpio_data;
                    idle_d     = '0;
                end
            end
            ST_CPU: begin
                if (gpio_wr) begin
                    cpu_data_d = gpio_data;
                    idle_d     = '0;
                end else if (step_hit) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_d = ST_PAT;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_cnt + IW'(1);
                    end
                end
            end
            default: state_d = ST_PAT;
        endcase
    end

    // LED source follows the next owner so ownership changes show on the same edge.
    always_comb begin
        led_d = pat_d;
        if (state_d == ST_CPU) begin
            led_d = cpu_data_d;
        end
    end

    // Timer, pattern generator and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            step_cnt <= '0;
            pat      <= 8'h01;
            dir      <= 1'b0;
            sel_q    <= SEL_CHASE;
            led_o    <= 8'h00;
            owner_o  <= 1'b0;
            step_o   <= 1'b0;
        end else begin
            step_cnt <= step_cnt_d;
            pat      <= pat_d;
            dir      <= dir_d;
            sel_q    <= sel_d;
            led_o    <= led_d;
            owner_o  <= (state_d == ST_CPU);
            step_o   <= (step_cnt_d == STEP_LAST);
        end
    end

endmodule

// File: tb/tb_led8_seq_arbiter.sv
// Directed bench for led8_seq_arbiter with STEP_CYCLES=4, IDLE_STEPS=3.
// Time reference e counts clock edges since reset release; outputs are
// sampled 1 ns after each rising edge. Steps end on edges where e%4==0.
module tb_led8_seq_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] gpio_data;
    logic       gpio_wr;
    logic [1:0] pat_sel;
    logic [7:0] led_o;
    logic       owner_o;
    logic       step_o;

    int tests = 0;
    int fails = 0;
    int e     = 0;

    logic [7:0] bnc [0:14];

    led8_seq_arbiter #(
        .STEP_CYCLES(4),
        .IDLE_STEPS (3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .gpio_data(gpio_data),
        .gpio_wr  (gpio_wr),
        .pat_sel  (pat_sel),
        .led_o    (led_o),
        .owner_o  (owner_o),
        .step_o   (step_o)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at e=%0d: got %02h expected %02h", tag, e, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at e=%0d: got %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        e++;
    endtask

    // Chase value shown after edge k while chase runs from reset.
    function automatic logic [7:0] chase(input int k);
        logic [7:0] one;
        one = 8'h01;
        return one << ((k / 4) % 8);
    endfunction

    initial begin
        bnc[0]  = 8'h01; bnc[1]  = 8'h02; bnc[2]  = 8'h04; bnc[3]  = 8'h08;
        bnc[4]  = 8'h10; bnc[5]  = 8'h20; bnc[6]  = 8'h40; bnc[7]  = 8'h80;
        bnc[8]  = 8'h40; bnc[9]  = 8'h20; bnc[10] = 8'h10; bnc[11] = 8'h08;
        bnc[12] = 8'h04; bnc[13] = 8'h02; bnc[14] = 8'h01;

        RESET     = 1'b0;
        gpio_wr   = 1'b0;
        gpio_data = 8'h00;
        pat_sel   = 2'b00;
        repeat (2) @(posedge CLK);
        #1;
        chk8("reset_led", led_o, 8'h00);
        chk1("reset_owner", owner_o, 1'b0);
        chk1("reset_step", step_o, 1'b0);
        #2 RESET = 1'b1;
        e = 0;

        // 1: chase from reset, step pulse every 4 cycles
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk8("chase_led", led_o, chase(e));
            chk1("chase_step", step_o, (e % 4) == 3);
            chk1("chase_owner", owner_o, 1'b0);
        end
        chk8("chase_wrap", led_o, 8'h01);

        // 2: write takes ownership, times out after 3 steps
        gpio_data = 8'hA5; gpio_wr = 1'b1;
        tick();
        gpio_wr = 1'b0;
        chk8("wr_led", led_o, 8'hA5);
        chk1("wr_owner", owner_o, 1'b1);
        while (e < 43) begin
            tick();
            chk1("hold_owner", owner_o, 1'b1);
            chk8("hold_led", led_o, 8'hA5);
        end
        tick();
        chk1("timeout_owner", owner_o, 1'b0);
        chk8("timeout_led", led_o, 8'h08);

        // 3: second write restarts the timeout
        gpio_data = 8'h3C; gpio_wr = 1'b1;
        tick();
        gpio_wr = 1'b0;
        chk8("w1_led", led_o, 8'h3C);
        while (e < 52) begin
            tick();
            chk1("w1_owner", owner_o, 1'b1);
            chk8("w1_hold", led_o, 8'h3C);
        end
        gpio_data = 8'hC3; gpio_wr = 1'b1;
        tick();
        gpio_wr = 1'b0;
        chk8("w2_led", led_o, 8'hC3);
        while (e < 63) begin
            tick();
            chk1("w2_owner", owner_o, 1'b1);
            chk8("w2_hold", led_o, 8'hC3);
        end
        tick();
        chk1("w2_timeout_owner", owner_o, 1'b0);
        chk8("w2_timeout_led", led_o, 8'h01);

        // 4: write coincident with timeout step wins
        gpio_data = 8'h22; gpio_wr = 1'b1;
        tick();
        gpio_wr = 1'b0;
        chk8("w3_led", led_o, 8'h22);
        while (e < 75) begin
            tick();
            chk1("w3_owner", owner_o, 1'b1);
        end
        chk1("coinc_step", step_o, 1'b1);
        gpio_data = 8'h11; gpio_wr = 1'b1;
        tick();
        gpio_wr = 1'b0;
        chk1("coinc_owner", owner_o, 1'b1);
        chk8("coinc_led", led_o, 8'h11);
        while (e < 87) begin
            tick();
            chk1("coinc_hold_owner", owner_o, 1'b1);
            chk8("coinc_hold_led", led_o, 8'h11);
        end
        tick();
        chk1("coinc_timeout_owner", owner_o, 1'b0);
        chk8("coinc_timeout_led", led_o, 8'h40);

        // 5: bounce, blink, count; pat_sel changes mid-step
        tick(); tick();
        pat_sel = 2'b01;
        tick();
        chk8("sel_ignored", led_o, 8'h40);
        tick();
        chk8("bounce_seed", led_o, 8'h01);
        for (int j = 1; j <= 14; j++) begin
            repeat (4) tick();
            chk8("bounce_led", led_o, bnc[j]);
        end
        tick(); tick();
        pat_sel = 2'b10;
        tick(); tick();
        chk8("blink_seed", led_o, 8'h00);
        repeat (4) tick(); chk8("blink_1", led_o, 8'hFF);
        repeat (4) tick(); chk8("blink_2", led_o, 8'h00);
        repeat (4) tick(); chk8("blink_3", led_o, 8'hFF);
        tick(); tick();
        pat_sel = 2'b11;
        tick(); tick();
        chk8("count_seed", led_o, 8'h00);
        for (int j = 1; j <= 256; j++) begin
            repeat (4) tick();
            chk8("count_led", led_o, 8'(j));
        end
        chk8("count_wrap", led_o, 8'h00);

        // 6: asynchronous reset while CPU owns the LEDs
        gpio_data = 8'h5A; gpio_wr = 1'b1;
        tick();
        gpio_wr = 1'b0;
        chk8("pre_rst_led", led_o, 8'h5A);
        chk1("pre_rst_owner", owner_o, 1'b1);
        pat_sel = 2'b00;
        tick();
        #2 RESET = 1'b0;
        #1;
        chk8("async_rst_led", led_o, 8'h00);
        chk1("async_rst_owner", owner_o, 1'b0);
        chk1("async_rst_step", step_o, 1'b0);
        @(posedge CLK);
        #1;
        chk8("in_rst_led", led_o, 8'h00);
        #1 RESET = 1'b1;
        e = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk8("rerun_led", led_o, chase(e));
            chk1("rerun_step", step_o, (e % 4) == 3);
            chk1("rerun_owner", owner_o, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
